imem_loader: RTL and testbench

- Instruction memory plus byte-stream boot loader, directly upstream of the single-cycle core's instruction input.
- While loading, it holds the core in reset via `core_hold`.
- It assembles an incoming byte stream into little-endian 32-bit words and writes them to its array.
- After the last word it releases the core and serves `instruction` combinationally from `currentpc`.

---
 rtl/imem_loader_pkg.sv | 10 +
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader_array.sv | 27 ++
 rtl/imem_loader.sv | 115 +++++++++++
 tb/tb_imem_loader.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Everything here is imported by the loader, its memory array and its interface users.
package imem_loader_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} loader_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream boot port plus the fetch port toward the single-cycle core.
// The loader uses the slave view; the stream source and core use the master view.
interface imem_loader_if #(
   parameter int WIDTH   = 32,
   parameter int PCWIDTH = 8
);

   logic               in_valid;
   logic [7:0]         in_data;
   logic               in_ready;
   logic               reload;
   logic [PCWIDTH-1:0] currentpc;
   logic [WIDTH-1:0]   instruction;
   logic               core_hold;
   logic               load_err;
   logic [PCWIDTH-1:0] words_loaded;

   modport master (
      output in_valid, in_data, reload, currentpc,
      input  in_ready, instruction, core_hold, load_err, words_loaded
   );

   modport slave (
      input  in_valid, in_data, reload, currentpc,
      output in_ready, instruction, core_hold, load_err, words_loaded
   );

endinterface

// File: rtl/imem_loader_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the loader always rewrites what the core runs.
module imem_array #(
   parameter int WIDTH = 32,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   localparam int DEPTH = 2**AW;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a header word count then little-endian bytes, fills the
// instruction array while holding the core in reset, then serves fetches.
import imem_loader_pkg::*;

module imem_loader #(
   parameter int WIDTH   = 32,
   parameter int PCWIDTH = 8
) (
   input logic          clk,
   input logic          rst,
   imem_loader_if.slave bus
);

   localparam int          AW    = PCWIDTH - 2;
   localparam int unsigned DEPTH = 2**AW;
   // Wide enough to count past DEPTH so out-of-range words are dropped, never aliased.
   localparam int          IW    = (AW + 1 > 8) ? AW + 1 : 8;

   loader_state_t      state, state_next;
   logic [1:0]         byte_cnt;
   logic [IW-1:0]      word_idx;
   logic [7:0]         words_left;
   logic [23:0]        shift;
   logic [PCWIDTH-1:0] words_loaded;
   logic               load_err;
   logic               in_ready;
   logic               accept;
   logic               last_byte;
   logic               idx_ok;
   logic               we;
   logic [WIDTH-1:0]   rdata;

   assign accept    = bus.in_valid & in_ready;
   assign last_byte = (state == LOAD) && (byte_cnt == 2'(BYTES_PER_WORD - 1));
   assign idx_ok    = 32'(word_idx) < DEPTH;
   assign we        = accept & last_byte & idx_ok;

   assign bus.in_ready     = in_ready;
   assign bus.load_err     = load_err;
   assign bus.words_loaded = words_loaded;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next      = state;
      in_ready        = (state != RUN) & ~bus.reload;
      bus.core_hold   = (state != RUN);
      bus.instruction = (state == RUN) ? rdata : NOP_INSTR;
      if (bus.reload) begin
         state_next = IDLE;
      end else begin
         unique case (state)
            IDLE: if (accept) state_next = (bus.in_data == 8'd0) ? RUN : LOAD;
            LOAD: if (accept && last_byte && words_left == 8'd1) state_next = RUN;
            RUN:  state_next = RUN;
            default: state_next = IDLE;
         endcase
      end
   end

   // Byte assembler and counters; reload discards any partial word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_cnt     <= '0;
         word_idx     <= '0;
         words_left   <= '0;
         shift        <= '0;
         words_loaded <= '0;
         load_err     <= 1'b0;
      end else if (bus.reload) begin
         byte_cnt     <= '0;
         word_idx     <= '0;
         words_left   <= '0;
         shift        <= '0;
         words_loaded <= '0;
         load_err     <= 1'b0;
      end else if (accept) begin
         if (state == IDLE && bus.in_data != 8'd0) begin
            words_left   <= bus.in_data;
            word_idx     <= '0;
            words_loaded <= '0;
            if (32'(bus.in_data) > DEPTH) load_err <= 1'b1;
         end else if (state == LOAD) begin
            if (last_byte) begin
               byte_cnt   <= '0;
               word_idx   <= word_idx + IW'(1);
               words_left <= words_left - 8'd1;
               if (words_loaded != '1) words_loaded <= words_loaded + PCWIDTH'(1);
            end else begin
               byte_cnt <= byte_cnt + 2'd1;
               shift    <= {bus.in_data, shift[23:8]};
            end
         end
      end
   end

   imem_array #(
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (word_idx[AW-1:0]),
      .wdata ({bus.in_data, shift}),
      .raddr (bus.currentpc[PCWIDTH-1:2]),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for the boot loader: header/byte streams, overflow, reload and async reset.
module tb_imem_loader;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic [31:0] exp_mem [64];

   imem_loader_if #(.WIDTH(32), .PCWIDTH(8)) bus ();

   imem_loader #(.WIDTH(32), .PCWIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ovf_word(input int k);
      logic [7:0] kb;
      kb = 8'(k);
      return {8'hC0, kb, 8'h5A, kb ^ 8'hFF};
   endfunction

   // Drives one byte at the falling edge and lets it transfer on the next rising edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      t = 0;
      while (!bus.in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) begin
         checks++;
         failures++;
         $display("[TB] FAIL send_timeout: in_ready got %b required 1", bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hEE;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8], gap);
      end
   endtask

   task automatic pulse_reload();
      @(negedge clk);
      bus.reload = 1'b1;
      @(posedge clk);
      #1;
      bus.reload = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      checks++;
      if (bus.core_hold !== 1'b1) begin failures++; $display("[TB] FAIL reset_core_hold: got %b required 1", bus.core_hold); end
      checks++;
      if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b required 1", bus.in_ready); end
      checks++;
      if (bus.load_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_load_err: got %b required 0", bus.load_err); end
      checks++;
      if (bus.words_loaded !== 8'd0) begin failures++; $display("[TB] FAIL reset_words_loaded: got %0d required 0", bus.words_loaded); end
      checks++;
      if (bus.instruction !== 32'h0) begin failures++; $display("[TB] FAIL reset_instruction: got %h required 00000000", bus.instruction); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single_word();
      send_byte(8'h01, 0);
      send_byte(8'h20, 0);
      send_byte(8'h00, 0);
      send_byte(8'h08, 0);
      checks++;
      if (bus.core_hold !== 1'b1) begin failures++; $display("[TB] FAIL single_hold_before: got %b required 1", bus.core_hold); end
      send_byte(8'h20, 0);
      exp_mem[0] = 32'h2008_0020;
      checks++;
      if (bus.core_hold !== 1'b0) begin failures++; $display("[TB] FAIL single_hold_after: got %b required 0", bus.core_hold); end
      checks++;
      if (bus.words_loaded !== 8'd1) begin failures++; $display("[TB] FAIL single_words_loaded: got %0d required 1", bus.words_loaded); end
      checks++;
      if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL single_in_ready_run: got %b required 0", bus.in_ready); end
      for (int pc = 0; pc < 4; pc++) begin
         bus.currentpc = 8'(pc);
         #1;
         checks++;
         if (bus.instruction !== 32'h2008_0020) begin
            failures++;
            $display("[TB] FAIL single_fetch_pc%0d: got %h required 20080020", pc, bus.instruction);
         end
      end
      bus.currentpc = 8'd0;
   endtask

   task automatic test_multi_word();
      logic [31:0] words [3];
      logic        ready_bad;
      words[0] = 32'h8C01_0004;
      words[1] = 32'hAC02_0008;
      words[2] = 32'h1234_5678;
      pulse_reload();
      checks++;
      if (bus.core_hold !== 1'b1 || bus.words_loaded !== 8'd0) begin
         failures++;
         $display("[TB] FAIL multi_after_reload: hold %b words %0d required 1 0", bus.core_hold, bus.words_loaded);
      end
      ready_bad = 1'b0;
      send_byte(8'h03, 0);
      for (int w = 0; w < 3; w++) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.in_ready !== 1'b1) ready_bad = 1'b1;
            send_byte(words[w][8*i +: 8], int'($urandom_range(0, 3)));
         end
         exp_mem[w] = words[w];
      end
      checks++;
      if (ready_bad) begin failures++; $display("[TB] FAIL multi_ready_during_load: got 0 required 1"); end
      checks++;
      if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL multi_ready_run: got %b required 0", bus.in_ready); end
      checks++;
      if (bus.words_loaded !== 8'd3) begin failures++; $display("[TB] FAIL multi_words_loaded: got %0d required 3", bus.words_loaded); end
      for (int w = 0; w < 3; w++) begin
         bus.currentpc = 8'(4 * w);
         #1;
         checks++;
         if (bus.instruction !== words[w]) begin
            failures++;
            $display("[TB] FAIL multi_fetch_word%0d: got %h required %h", w, bus.instruction, words[w]);
         end
      end
      bus.currentpc = 8'd0;
   endtask

   task automatic test_zero_header();
      pulse_reload();
      send_byte(8'h00, 0);
      checks++;
      if (bus.core_hold !== 1'b0) begin failures++; $display("[TB] FAIL zero_core_hold: got %b required 0", bus.core_hold); end
      checks++;
      if (bus.words_loaded !== 8'd0) begin failures++; $display("[TB] FAIL zero_words_loaded: got %0d required 0", bus.words_loaded); end
      bus.currentpc = 8'd4;
      #1;
      checks++;
      if (bus.instruction !== 32'hAC02_0008) begin failures++; $display("[TB] FAIL zero_fetch_old: got %h required ac020008", bus.instruction); end
      bus.currentpc = 8'd0;
   endtask

   task automatic test_overflow();
      pulse_reload();
      send_byte(8'h42, 0);
      checks++;
      if (bus.load_err !== 1'b1) begin failures++; $display("[TB] FAIL ovf_err_at_header: got %b required 1", bus.load_err); end
      for (int w = 0; w < 66; w++) begin
         for (int i = 0; i < 4; i++) begin
            if (w == 65 && i == 3) begin
               checks++;
               if (bus.core_hold !== 1'b1) begin failures++; $display("[TB] FAIL ovf_hold_before_last: got %b required 1", bus.core_hold); end
            end
            send_byte(ovf_word(w)[8*i +: 8], 0);
         end
         if (w < 64) exp_mem[w] = ovf_word(w);
      end
      checks++;
      if (bus.core_hold !== 1'b0) begin failures++; $display("[TB] FAIL ovf_run_reached: got %b required 0", bus.core_hold); end
      checks++;
      if (bus.load_err !== 1'b1) begin failures++; $display("[TB] FAIL ovf_err_sticky: got %b required 1", bus.load_err); end
      checks++;
      if (bus.words_loaded !== 8'd66) begin failures++; $display("[TB] FAIL ovf_words_loaded: got %0d required 66", bus.words_loaded); end
      bus.currentpc = 8'd0;
      #1;
      checks++;
      if (bus.instruction !== ovf_word(0)) begin failures++; $display("[TB] FAIL ovf_no_alias_word0: got %h required %h", bus.instruction, ovf_word(0)); end
      bus.currentpc = 8'd252;
      #1;
      checks++;
      if (bus.instruction !== ovf_word(63)) begin failures++; $display("[TB] FAIL ovf_last_word: got %h required %h", bus.instruction, ovf_word(63)); end
      bus.currentpc = 8'd0;
   endtask

   task automatic test_reload_partial();
      pulse_reload();
      checks++;
      if (bus.load_err !== 1'b0) begin failures++; $display("[TB] FAIL reload_clears_err: got %b required 0", bus.load_err); end
      send_byte(8'h02, 0);
      send_word(32'h0BAD_F00D, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      pulse_reload();
      checks++;
      if (bus.core_hold !== 1'b1 || bus.words_loaded !== 8'd0) begin
         failures++;
         $display("[TB] FAIL reload_mid_load: hold %b words %0d required 1 0", bus.core_hold, bus.words_loaded);
      end
      send_byte(8'h01, 0);
      send_word(32'h2402_0005, 1);
      exp_mem[0] = 32'h2402_0005;
      checks++;
      if (bus.instruction !== 32'h2402_0005) begin failures++; $display("[TB] FAIL reload_new_word0: got %h required 24020005", bus.instruction); end
      checks++;
      if (bus.words_loaded !== 8'd1 || bus.load_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reload_status: words %0d err %b required 1 0", bus.words_loaded, bus.load_err);
      end
      bus.currentpc = 8'd4;
      #1;
      checks++;
      if (bus.instruction !== exp_mem[1]) begin failures++; $display("[TB] FAIL reload_word1_untouched: got %h required %h", bus.instruction, exp_mem[1]); end
      bus.currentpc = 8'd0;
   endtask

   task automatic test_async_reset();
      pulse_reload();
      send_byte(8'h02, 0);
      send_byte(8'h77, 0);
      send_byte(8'h66, 0);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.core_hold !== 1'b1) begin failures++; $display("[TB] FAIL async_core_hold: got %b required 1", bus.core_hold); end
      checks++;
      if (bus.instruction !== 32'h0) begin failures++; $display("[TB] FAIL async_instruction: got %h required 00000000", bus.instruction); end
      checks++;
      if (bus.words_loaded !== 8'd0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL async_status: words %0d ready %b required 0 1", bus.words_loaded, bus.in_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      send_byte(8'h01, 0);
      send_word(32'h3C01_1000, 0);
      checks++;
      if (bus.core_hold !== 1'b0 || bus.instruction !== 32'h3C01_1000) begin
         failures++;
         $display("[TB] FAIL async_next_is_header: hold %b instr %h required 0 3c011000", bus.core_hold, bus.instruction);
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.reload    = 1'b0;
      bus.currentpc = 8'd0;
      test_reset();
      test_single_word();
      test_multi_word();
      test_zero_header();
      test_overflow();
      test_reload_partial();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
